// File: rtl/acq_sequencer_pkg.sv
// acq_sequencer_pkg
//   Shared types and constants for the acquisition sequencer slice.
//   - acq_state_t : sequencer FSM states (IDLE, ARM, CAPTURE)
//   - DEFAULT_*   : default address / frame-count widths
//   - all_ones()  : all-ones constant for a given bit width (up to 32 bits)
package acq_sequencer_pkg;

  localparam int DEFAULT_BRAM_WIDTH  = 13;
  localparam int DEFAULT_FRAME_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2
  } acq_state_t;

  // Widths of 32 or more saturate to a full 32-bit all-ones word.
  // Callers cast the result down to the width they actually need.
  function automatic logic [31:0] all_ones(input int unsigned width);
    if (width >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/acq_sequencer_if.sv
// acq_sequencer_if
//   Bundles the sequencer's control-register side and its BRAM write-port side.
//   Control side : start, abort, num_frames -> sequencer; busy, done, aborted <- sequencer
//   Datapath side: address -> sequencer; wen, wr_addr, first_frame, frame_idx <- sequencer
//   modport master : environment (control registers + datapath) driving the sequencer
//   modport slave  : the sequencer itself
interface acq_sequencer_if
  import acq_sequencer_pkg::*;
#(
  parameter int BRAM_WIDTH  = DEFAULT_BRAM_WIDTH,
  parameter int FRAME_WIDTH = DEFAULT_FRAME_WIDTH
);

  logic                   start;
  logic                   abort;
  logic [FRAME_WIDTH-1:0] num_frames;
  logic [BRAM_WIDTH-1:0]  address;

  logic                   wen;
  logic [BRAM_WIDTH-1:0]  wr_addr;
  logic                   first_frame;
  logic [FRAME_WIDTH-1:0] frame_idx;
  logic                   busy;
  logic                   done;
  logic                   aborted;

  modport master (
    output start, abort, num_frames, address,
    input  wen, wr_addr, first_frame, frame_idx, busy, done, aborted
  );

  modport slave (
    input  start, abort, num_frames, address,
    output wen, wr_addr, first_frame, frame_idx, busy, done, aborted
  );

endinterface

// File: rtl/acq_frame_counter.sv
// acq_frame_counter
//   Sample counter (position inside a frame) and frame counter (which frame of
//   the sequence is being written). The FSM in acq_sequencer decides when to
//   clear and advance; this block only counts and reports the boundaries.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     clear_sample    : zero the sample counter (alignment edge)
//     clear_frame     : zero the frame counter (sequence start)
//     enable          : advance one sample; rolls into the next frame at the end
//     last_frame_idx  : index of the final frame of this sequence (frames-1)
//     sample_cnt      : current sample index within the frame
//     frame_idx       : current frame index
//     last_sample     : sample_cnt is at its all-ones value
//     last_frame      : frame_idx equals last_frame_idx
module acq_frame_counter
  import acq_sequencer_pkg::*;
#(
  parameter int BRAM_WIDTH  = DEFAULT_BRAM_WIDTH,
  parameter int FRAME_WIDTH = DEFAULT_FRAME_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_sample,
  input  logic                   clear_frame,
  input  logic                   enable,
  input  logic [FRAME_WIDTH-1:0] last_frame_idx,
  output logic [BRAM_WIDTH-1:0]  sample_cnt,
  output logic [FRAME_WIDTH-1:0] frame_idx,
  output logic                   last_sample,
  output logic                   last_frame
);

  localparam logic [BRAM_WIDTH-1:0] SAMPLE_MAX = BRAM_WIDTH'(all_ones(BRAM_WIDTH));

  // The sample counter wraps naturally from all-ones to zero, which is what
  // makes consecutive frames contiguous. The frame counter only steps on that
  // wrap and never past the final frame, so it still shows the last frame
  // index after a sequence completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt <= '0;
      frame_idx  <= '0;
    end else begin
      if (clear_sample) begin
        sample_cnt <= '0;
      end else if (enable) begin
        sample_cnt <= sample_cnt + BRAM_WIDTH'(1);
      end

      if (clear_frame) begin
        frame_idx <= '0;
      end else if (enable && last_sample && !last_frame) begin
        frame_idx <= frame_idx + FRAME_WIDTH'(1);
      end
    end
  end

  assign last_sample = (sample_cnt == SAMPLE_MAX);
  assign last_frame  = (frame_idx == last_frame_idx);

endmodule

// File: rtl/acq_sequencer.sv
// acq_sequencer
//   Acquisition sequencer for the BRAM capture path. A start request arms the
//   block; it then waits for the free-running datapath address to wrap to zero
//   and asserts the BRAM write enable for whole frames, back-to-back, for the
//   configured number of frames so a downstream accumulator can average them.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     bus      : acq_sequencer_if.slave
//                in : start, abort (priority over start), num_frames, address
//                out: wen, wr_addr, first_frame, frame_idx, busy, done, aborted
module acq_sequencer
  import acq_sequencer_pkg::*;
#(
  parameter int BRAM_WIDTH  = DEFAULT_BRAM_WIDTH,
  parameter int FRAME_WIDTH = DEFAULT_FRAME_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  acq_sequencer_if.slave bus
);

  logic                   start;
  logic                   abort;
  logic [FRAME_WIDTH-1:0] num_frames;
  logic [BRAM_WIDTH-1:0]  address;

  acq_state_t             state_q;
  acq_state_t             state_d;
  logic [FRAME_WIDTH-1:0] last_frame_idx_q;
  logic                   wen_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   aborted_q;

  logic                   done_d;
  logic                   aborted_d;
  logic                   seq_start;
  logic                   cnt_clear_sample;
  logic                   cnt_enable;

  logic [BRAM_WIDTH-1:0]  sample_cnt;
  logic [FRAME_WIDTH-1:0] frame_idx;
  logic                   last_sample;
  logic                   last_frame;

  assign start      = bus.start;
  assign abort      = bus.abort;
  assign num_frames = bus.num_frames;
  assign address    = bus.address;

  acq_frame_counter #(
    .BRAM_WIDTH  (BRAM_WIDTH),
    .FRAME_WIDTH (FRAME_WIDTH)
  ) u_frame_counter (
    .clk            (clk),
    .rst            (rst),
    .clear_sample   (cnt_clear_sample),
    .clear_frame    (seq_start),
    .enable         (cnt_enable),
    .last_frame_idx (last_frame_idx_q),
    .sample_cnt     (sample_cnt),
    .frame_idx      (frame_idx),
    .last_sample    (last_sample),
    .last_frame     (last_frame)
  );

  // Next-state and counter control. Abort wins over everything in ARM and
  // CAPTURE; in IDLE an abort only suppresses a simultaneous start. The
  // address is deliberately ignored in IDLE, so a zero address on the same
  // edge that leaves IDLE does not align the capture.
  always_comb begin
    state_d          = state_q;
    done_d           = 1'b0;
    aborted_d        = 1'b0;
    seq_start        = 1'b0;
    cnt_clear_sample = 1'b0;
    cnt_enable       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          seq_start = 1'b1;
          state_d   = ARM;
        end
      end

      ARM: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (address == '0) begin
          cnt_clear_sample = 1'b1;
          state_d          = CAPTURE;
        end
      end

      CAPTURE: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_enable = 1'b1;
          if (last_sample && last_frame) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs. wen and busy are decoded from the next
  // state so they change on the same edge as the state itself. The frame
  // count is captured as frames-1 (with 0 treated as 1) so the end-of-sequence
  // test is a plain equality against the frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      last_frame_idx_q <= '0;
      wen_q            <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      aborted_q        <= 1'b0;
    end else begin
      state_q   <= state_d;
      wen_q     <= (state_d == CAPTURE);
      busy_q    <= (state_d != IDLE);
      done_q    <= done_d;
      aborted_q <= aborted_d;
      if (seq_start) begin
        last_frame_idx_q <= (num_frames == '0) ? '0 : num_frames - FRAME_WIDTH'(1);
      end
    end
  end

  assign bus.wen         = wen_q;
  assign bus.wr_addr     = sample_cnt;
  assign bus.first_frame = wen_q && (frame_idx == '0);
  assign bus.frame_idx   = frame_idx;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// tb_acq_sequencer
//   Directed self-checking bench for acq_sequencer with 4-bit addresses
//   (16-sample frames). The bench plays the datapath address counter itself,
//   advancing it by one just after every rising edge, so alignment delays can
//   be worked out by hand from the address value present at the start edge.
module tb_acq_sequencer;

  localparam int BW = 4;
  localparam int FW = 8;
  localparam int FRAME_LEN = 16;

  localparam int STOP_ABORT = 1;
  localparam int STOP_RESET = 2;

  logic clk;
  logic rst;

  int checks;
  int errors;

  acq_sequencer_if #(.BRAM_WIDTH(BW), .FRAME_WIDTH(FW)) bus ();

  acq_sequencer #(
    .BRAM_WIDTH  (BW),
    .FRAME_WIDTH (FW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: outputs are observed 1 time unit after the rising edge, and
  // the free-running address moves on to the value the next edge will see.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.address = bus.address + 4'd1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Control nibble {wen, busy, done, aborted}.
  function automatic logic [31:0] ctl();
    return 32'({bus.wen, bus.busy, bus.done, bus.aborted});
  endfunction

  // Request a sequence with the address at addr_at_start on the start edge,
  // then walk through ARM until the edge that sees address zero is next.
  task automatic apply_stimulus(input logic [FW-1:0] nf, input logic [BW-1:0] addr_at_start);
    bus.num_frames = nf;
    bus.address    = addr_at_start;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    check_output("arm_entry", ctl(), 32'b0100);
    for (int i = 0; i < 15 - int'(addr_at_start); i++) begin
      tick();
      check_output("arm_wait", ctl(), 32'b0100);
    end
  endtask

  // Walk the capture window cycle by cycle. Optionally pulse start and change
  // num_frames at poke_cycle, or abort / reset right after stop_cycle.
  task automatic capture(input int nframes, input int stop_cycle, input int stop_kind,
                         input int poke_cycle);
    for (int c = 0; c < nframes * FRAME_LEN; c++) begin
      tick();
      check_output("cap_ctl", ctl(), 32'b1100);
      check_output("cap_wr_addr", 32'(bus.wr_addr), 32'(c % FRAME_LEN));
      check_output("cap_frame_idx", 32'(bus.frame_idx), 32'(c / FRAME_LEN));
      check_output("cap_first_frame", 32'(bus.first_frame), 32'(c < FRAME_LEN));
      if (c == poke_cycle) begin
        bus.start      = 1'b1;
        bus.num_frames = 8'd5;
      end else begin
        bus.start = 1'b0;
      end
      if (c == stop_cycle) begin
        if (stop_kind == STOP_ABORT) begin
          bus.abort = 1'b1;
          tick();
          bus.abort = 1'b0;
          check_output("abort_pulse", ctl(), 32'b0001);
          tick();
          check_output("abort_after", ctl(), 32'b0000);
        end else begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          check_output("rst_ctl", ctl(), 32'b0000);
          check_output("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
          check_output("rst_frame_idx", 32'(bus.frame_idx), 32'd0);
          check_output("rst_first_frame", 32'(bus.first_frame), 32'd0);
        end
        return;
      end
    end
    tick();
    check_output("done_pulse", ctl(), 32'b0010);
    tick();
    check_output("done_after", ctl(), 32'b0000);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.num_frames  = 8'd1;
    bus.address     = 4'd0;

    // Reset state
    tick();
    tick();
    check_output("reset_ctl", ctl(), 32'b0000);
    check_output("reset_wr_addr", 32'(bus.wr_addr), 32'd0);
    check_output("reset_frame_idx", 32'(bus.frame_idx), 32'd0);
    check_output("reset_first_frame", 32'(bus.first_frame), 32'd0);
    rst = 1'b0;
    tick();
    check_output("idle_ctl", ctl(), 32'b0000);

    // Single frame, start with address at 5
    apply_stimulus(8'd1, 4'd5);
    capture(1, -1, 0, -1);

    // Three contiguous frames
    apply_stimulus(8'd3, 4'd5);
    capture(3, -1, 0, -1);

    // num_frames 0 runs one frame; address zero on the start edge must not align
    apply_stimulus(8'd0, 4'd0);
    capture(1, -1, 0, -1);

    // Abort at wr_addr 7 of frame 1
    apply_stimulus(8'd3, 4'd9);
    capture(3, FRAME_LEN + 7, STOP_ABORT, -1);

    // Abort together with start in IDLE: no sequence, no pulse
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    check_output("abort_start_idle", ctl(), 32'b0000);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tick();
    check_output("abort_start_idle_after", ctl(), 32'b0000);

    // Start re-pulsed and num_frames changed mid-capture: still two frames
    apply_stimulus(8'd2, 4'd12);
    capture(2, -1, 0, 3);

    // Reset during frame 1, then a clean sequence
    apply_stimulus(8'd2, 4'd3);
    capture(2, FRAME_LEN + 3, STOP_RESET, -1);
    tick();
    check_output("post_rst_idle", ctl(), 32'b0000);
    apply_stimulus(8'd1, 4'd7);
    capture(1, -1, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
